// File: rtl/collision_scanner_pkg.sv
// rtl/collision_scanner_pkg.sv - shared FSM encoding and width helpers for the collision scanner
// Purpose: state constants and elaboration-time width functions used by the
//          scanner top, its overlap comparator and the bus interface.
// Ports:   none (package).
package collision_scanner_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Index width, never narrower than one bit.
  function automatic int idx_width(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

  // Width that holds coordinate + size without wrapping.
  function automatic int sum_width(input int coord_w, input int size);
    int m;
    m = (coord_w > clog2(size + 1)) ? coord_w : clog2(size + 1);
    return m + 1;
  endfunction

endpackage

// File: rtl/collision_scanner_if.sv
// rtl/collision_scanner_if.sv - request/result bundle between game logic and the collision scanner
// Purpose: groups the scan request, snapshot inputs and result outputs.
// Ports:   master drives start/clear/player_*/obs_*; slave (the scanner)
//          drives busy/done/collision/hit_mask/first_hit/hit_count.
interface collision_scanner_if
  import collision_scanner_pkg::*;
#(
  parameter int NUM_OBSTACLES = 4,
  parameter int X_BITWIDTH    = 8,
  parameter int Y_BITWIDTH    = 9
);

  localparam int FW = idx_width(NUM_OBSTACLES);
  localparam int CW = clog2(NUM_OBSTACLES + 1);

  logic                               start;
  logic                               clear;
  logic [X_BITWIDTH-1:0]              player_x;
  logic [Y_BITWIDTH-1:0]              player_y;
  logic [NUM_OBSTACLES*X_BITWIDTH-1:0] obs_x;
  logic [NUM_OBSTACLES*Y_BITWIDTH-1:0] obs_y;
  logic [NUM_OBSTACLES-1:0]           obs_enable;
  logic                               busy;
  logic                               done;
  logic                               collision;
  logic [NUM_OBSTACLES-1:0]           hit_mask;
  logic [FW-1:0]                      first_hit;
  logic [CW-1:0]                      hit_count;

  modport master (
    output start, clear, player_x, player_y, obs_x, obs_y, obs_enable,
    input  busy, done, collision, hit_mask, first_hit, hit_count
  );

  modport slave (
    input  start, clear, player_x, player_y, obs_x, obs_y, obs_enable,
    output busy, done, collision, hit_mask, first_hit, hit_count
  );

endinterface

// File: rtl/collision_scanner_box_overlap.sv
// rtl/collision_scanner_box_overlap.sv - combinational strict overlap test for one box pair
// Purpose: reports whether player and obstacle boxes overlap; touching edges do not count.
// Ports:   px/py player top-left, ox/oy obstacle top-left, overlap result.
module collision_scanner_box_overlap
  import collision_scanner_pkg::*;
#(
  parameter int PX_W = 8,
  parameter int PY_W = 9,
  parameter int OX_W = 8,
  parameter int OY_W = 9,
  parameter int PW   = 50,
  parameter int PH   = 50,
  parameter int OW   = 50,
  parameter int OH   = 50
) (
  input  logic [PX_W-1:0] px,
  input  logic [PY_W-1:0] py,
  input  logic [OX_W-1:0] ox,
  input  logic [OY_W-1:0] oy,
  output logic            overlap
);

  // Compare in a widened domain so a box near the coordinate maximum cannot
  // wrap its far edge back around to a small value.
  localparam int XW = sum_width((PX_W > OX_W) ? PX_W : OX_W, (PW > OW) ? PW : OW);
  localparam int YW = sum_width((PY_W > OY_W) ? PY_W : OY_W, (PH > OH) ? PH : OH);

  logic [XW-1:0] pxe, oxe, px_end, ox_end;
  logic [YW-1:0] pye, oye, py_end, oy_end;

  assign pxe    = XW'(px);
  assign oxe    = XW'(ox);
  assign pye    = YW'(py);
  assign oye    = YW'(oy);
  assign px_end = pxe + XW'(PW);
  assign ox_end = oxe + XW'(OW);
  assign py_end = pye + YW'(PH);
  assign oy_end = oye + YW'(OH);

  assign overlap = (pxe < ox_end) && (px_end > oxe) &&
                   (pye < oy_end) && (py_end > oye);

endmodule

// File: rtl/collision_scanner.sv
// rtl/collision_scanner.sv - sequential multi-obstacle collision scanner with one shared comparator
// Purpose: on start, snapshots player and obstacle boxes, tests one obstacle
//          per clock, then publishes hit mask, lowest hit, hit count and collision.
// Ports:   clock, reset (async active-high), bus (collision_scanner_if.slave).
module collision_scanner
  import collision_scanner_pkg::*;
#(
  parameter int NUM_OBSTACLES = 4,
  parameter int X_BITWIDTH    = 8,
  parameter int Y_BITWIDTH    = 9,
  parameter int PLAYER_WIDTH  = 50,
  parameter int PLAYER_HEIGHT = 50,
  parameter int OBS_WIDTH     = 50,
  parameter int OBS_HEIGHT    = 50,
  parameter int STICKY        = 0
) (
  input  logic               clock,
  input  logic               reset,
  collision_scanner_if.slave bus
);

  localparam int IW = idx_width(NUM_OBSTACLES);
  localparam int CW = clog2(NUM_OBSTACLES + 1);

  logic [1:0]                          state;
  logic [IW-1:0]                       idx;
  logic [X_BITWIDTH-1:0]               px_q;
  logic [Y_BITWIDTH-1:0]               py_q;
  logic [NUM_OBSTACLES*X_BITWIDTH-1:0] ox_q;
  logic [NUM_OBSTACLES*Y_BITWIDTH-1:0] oy_q;
  logic [NUM_OBSTACLES-1:0]            en_q;

  // Scratch results, only visible to the outside after DONE.
  logic [NUM_OBSTACLES-1:0]            mask_s;
  logic [CW-1:0]                       cnt_s;
  logic [IW-1:0]                       first_s;

  logic                                done_q;
  logic                                coll_q;
  logic                                coll_next;
  logic [NUM_OBSTACLES-1:0]            mask_q;
  logic [IW-1:0]                       first_q;
  logic [CW-1:0]                       cnt_q;

  logic [X_BITWIDTH-1:0]               ox_sel;
  logic [Y_BITWIDTH-1:0]               oy_sel;
  logic                                overlap;
  logic                                hit;
  logic                                last;

  assign ox_sel = ox_q[idx*X_BITWIDTH +: X_BITWIDTH];
  assign oy_sel = oy_q[idx*Y_BITWIDTH +: Y_BITWIDTH];
  assign hit    = overlap & en_q[idx];
  assign last   = (idx == IW'(NUM_OBSTACLES - 1));

  collision_scanner_box_overlap #(
    .PX_W (X_BITWIDTH),
    .PY_W (Y_BITWIDTH),
    .OX_W (X_BITWIDTH),
    .OY_W (Y_BITWIDTH),
    .PW   (PLAYER_WIDTH),
    .PH   (PLAYER_HEIGHT),
    .OW   (OBS_WIDTH),
    .OH   (OBS_HEIGHT)
  ) u_box_overlap (
    .px      (px_q),
    .py      (py_q),
    .ox      (ox_sel),
    .oy      (oy_sel),
    .overlap (overlap)
  );

  // Sticky mode: clear wins first, then a completing scan ORs its result in.
  always_comb begin
    coll_next = coll_q;
    if (STICKY != 0) begin
      if (bus.clear) coll_next = 1'b0;
      if (state == ST_DONE) coll_next = coll_next | (|mask_s);
    end else if (state == ST_DONE) begin
      coll_next = |mask_s;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      en_q    <= '0;
      mask_s  <= '0;
      cnt_s   <= '0;
      first_s <= '0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      mask_q  <= '0;
      first_q <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      coll_q <= coll_next;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            px_q    <= bus.player_x;
            py_q    <= bus.player_y;
            ox_q    <= bus.obs_x;
            oy_q    <= bus.obs_y;
            en_q    <= bus.obs_enable;
            mask_s  <= '0;
            cnt_s   <= '0;
            first_s <= '0;
            idx     <= '0;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (hit) begin
            mask_s[idx] <= 1'b1;
            cnt_s       <= cnt_s + CW'(1);
            // Index order is ascending, so the first hit seen is the lowest.
            if (cnt_s == '0) first_s <= idx;
          end
          if (last) state <= ST_DONE;
          else      idx   <= idx + IW'(1);
        end
        ST_DONE: begin
          mask_q  <= mask_s;
          first_q <= first_s;
          cnt_q   <= cnt_s;
          done_q  <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.collision = coll_q;
  assign bus.hit_mask  = mask_q;
  assign bus.first_hit = first_q;
  assign bus.hit_count = cnt_q;

endmodule

// File: tb/tb_collision_scanner.sv
// tb/tb_collision_scanner.sv - self-checking bench for collision_scanner
module tb_collision_scanner;

  localparam int N  = 4;
  localparam int XB = 8;
  localparam int YB = 9;

  typedef struct {
    string       name;
    logic [7:0]  px;
    logic [8:0]  py;
    logic [31:0] ox;
    logic [35:0] oy;
    logic [3:0]  en;
    logic [3:0]  mask;
    logic [1:0]  first;
    logic [2:0]  cnt;
    logic        coll;
  } vec_t;

  typedef struct {
    string      name;
    logic [3:0] mask;
    logic [1:0] first;
    logic [2:0] cnt;
    logic       coll;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   failed = 0;
  int   done0_cnt = 0;
  exp_t sbq[$];
  vec_t vecs[8];

  always #5 clock = ~clock;

  collision_scanner_if #(.NUM_OBSTACLES(N), .X_BITWIDTH(XB), .Y_BITWIDTH(YB)) bus0 ();
  collision_scanner_if #(.NUM_OBSTACLES(N), .X_BITWIDTH(XB), .Y_BITWIDTH(YB)) bus1 ();

  collision_scanner #(.NUM_OBSTACLES(N), .X_BITWIDTH(XB), .Y_BITWIDTH(YB), .STICKY(0))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));
  collision_scanner #(.NUM_OBSTACLES(N), .X_BITWIDTH(XB), .Y_BITWIDTH(YB), .STICKY(1))
    dut1 (.clock(clock), .reset(reset), .bus(bus1));

  assign bus1.player_x   = bus0.player_x;
  assign bus1.player_y   = bus0.player_y;
  assign bus1.obs_x      = bus0.obs_x;
  assign bus1.obs_y      = bus0.obs_y;
  assign bus1.obs_enable = bus0.obs_enable;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse of the non-sticky scanner pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus0.done === 1'b1) begin
        done0_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check({e.name, "_mask"},  32'(bus0.hit_mask),  32'(e.mask));
          check({e.name, "_first"}, 32'(bus0.first_hit), 32'(e.first));
          check({e.name, "_count"}, 32'(bus0.hit_count), 32'(e.cnt));
          check({e.name, "_coll"},  32'(bus0.collision), 32'(e.coll));
        end
      end
    end
  end

  task automatic apply(input vec_t v);
    bus0.player_x   = v.px;
    bus0.player_y   = v.py;
    bus0.obs_x      = v.ox;
    bus0.obs_y      = v.oy;
    bus0.obs_enable = v.en;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.name = v.name; e.mask = v.mask; e.first = v.first; e.cnt = v.cnt; e.coll = v.coll;
    sbq.push_back(e);
  endtask

  // Runs one scan on the non-sticky DUT and checks latency and busy length.
  task automatic run0(input vec_t v);
    int lat;
    int busy_n;
    @(negedge clock);
    apply(v);
    push_exp(v);
    bus0.start = 1'b1;
    @(posedge clock);
    #1;
    bus0.start = 1'b0;
    busy_n = int'(bus0.busy);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      #1;
      if (bus0.done) begin
        lat = k;
        break;
      end
      busy_n += int'(bus0.busy);
    end
    check({v.name, "_latency"}, 32'(lat), 32'(N + 1));
    check({v.name, "_busy_cycles"}, 32'(busy_n), 32'(N + 1));
  endtask

  // Runs one scan on the sticky DUT, optionally with clear during the DONE cycle.
  task automatic run1(input vec_t v, input logic clr_at_done, input logic exp_coll, input string nm);
    int lat;
    @(negedge clock);
    apply(v);
    bus1.start = 1'b1;
    @(posedge clock);
    #1;
    bus1.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == N + 1) bus1.clear = clr_at_done;
      @(posedge clock);
      #1;
      if (bus1.done) begin
        lat = k;
        break;
      end
    end
    bus1.clear = 1'b0;
    check({nm, "_latency"}, 32'(lat), 32'(N + 1));
    check({nm, "_coll"}, 32'(bus1.collision), 32'(exp_coll));
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_busy"},  32'(bus0.busy),      32'd0);
    check({nm, "_done"},  32'(bus0.done),      32'd0);
    check({nm, "_coll"},  32'(bus0.collision), 32'd0);
    check({nm, "_mask"},  32'(bus0.hit_mask),  32'd0);
    check({nm, "_first"}, 32'(bus0.first_hit), 32'd0);
    check({nm, "_count"}, 32'(bus0.hit_count), 32'd0);
    check({nm, "_s_coll"}, 32'(bus1.collision), 32'd0);
  endtask

  initial begin
    int d0;
    //          name       px   py   ox {3,2,1,0}                  oy {3,2,1,0}                          en       mask     f  cnt coll
    vecs[0] = '{"v1_basic",  8'd10,  9'd10,  {8'd200, 8'd200, 8'd200, 8'd40},  {9'd200, 9'd200, 9'd200, 9'd40},  4'b1111, 4'b0001, 2'd0, 3'd1, 1'b1};
    vecs[1] = '{"v2_touch",  8'd0,   9'd0,   {8'd200, 8'd50,  8'd200, 8'd200}, {9'd200, 9'd0,   9'd200, 9'd200}, 4'b1111, 4'b0000, 2'd0, 3'd0, 1'b0};
    vecs[2] = '{"v3_enable", 8'd100, 9'd100, {8'd80,  8'd200, 8'd120, 8'd0},   {9'd60,  9'd300, 9'd130, 9'd0},   4'b0111, 4'b0010, 2'd1, 3'd1, 1'b1};
    vecs[3] = '{"v4_wrapx",  8'd250, 9'd10,  {8'd0,   8'd0,   8'd0,   8'd0},   {9'd10,  9'd10,  9'd10,  9'd10},  4'b1111, 4'b0000, 2'd0, 3'd0, 1'b0};
    vecs[4] = '{"v5_nearmax",8'd250, 9'd480, {8'd240, 8'd0,   8'd220, 8'd0},   {9'd511, 9'd0,   9'd470, 9'd480}, 4'b1111, 4'b1010, 2'd1, 3'd2, 1'b1};
    vecs[5] = '{"v6_all",    8'd100, 9'd100, {8'd100, 8'd100, 8'd100, 8'd100}, {9'd100, 9'd100, 9'd100, 9'd100}, 4'b1111, 4'b1111, 2'd0, 3'd4, 1'b1};
    vecs[6] = '{"v7_edges",  8'd100, 9'd100, {8'd150, 8'd149, 8'd100, 8'd100}, {9'd100, 9'd100, 9'd149, 9'd150}, 4'b1111, 4'b0110, 2'd1, 3'd2, 1'b1};
    vecs[7] = '{"v8_left",   8'd60,  9'd100, {8'd60,  8'd60,  8'd11,  8'd10},  {9'd100, 9'd100, 9'd100, 9'd100}, 4'b0011, 4'b0010, 2'd1, 3'd1, 1'b1};

    reset = 1'b1;
    bus0.start = 1'b0; bus0.clear = 1'b0;
    bus1.start = 1'b0; bus1.clear = 1'b0;
    apply(vecs[0]);
    repeat (3) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // Table: consecutive runs start in the cycle done is high (back-to-back).
    for (int i = 0; i < 8; i++) run0(vecs[i]);

    // Results hold until the next scan; clear does nothing when not sticky.
    @(negedge clock);
    bus0.clear = 1'b1;
    @(negedge clock);
    bus0.clear = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("hold_mask", 32'(bus0.hit_mask), 32'(vecs[7].mask));
    check("nonsticky_clear_coll", 32'(bus0.collision), 32'd1);

    // Start pulses while busy and inputs changed mid-scan: one done, snapshot results.
    d0 = done0_cnt;
    @(negedge clock);
    apply(vecs[0]);
    push_exp(vecs[0]);
    bus0.start = 1'b1;
    @(negedge clock);
    bus0.obs_x[7:0]   = 8'd200;
    bus0.obs_enable   = 4'b0000;
    repeat (3) @(negedge clock);
    bus0.start = 1'b0;
    repeat (12) @(posedge clock);
    #1;
    check("busy_start_single_done", 32'(done0_cnt - d0), 32'd1);

    // Reset during the second SCAN cycle: no done, everything back to zero.
    d0 = done0_cnt;
    @(negedge clock);
    apply(vecs[5]);
    bus0.start = 1'b1;
    @(posedge clock);
    #1;
    bus0.start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero("midscan_reset");
    @(negedge clock);
    reset = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    check("midscan_no_done", 32'(done0_cnt - d0), 32'd0);
    check_zero("after_reset");
    run0(vecs[6]);

    // Sticky behaviour on the second instance.
    run1(vecs[0], 1'b0, 1'b1, "s_hit");
    run1(vecs[1], 1'b0, 1'b1, "s_miss_holds");
    @(negedge clock);
    bus1.clear = 1'b1;
    @(posedge clock);
    #1;
    bus1.clear = 1'b0;
    check("s_clear", 32'(bus1.collision), 32'd0);
    run1(vecs[0], 1'b0, 1'b1, "s_hit2");
    run1(vecs[1], 1'b1, 1'b0, "s_clear_done_miss");
    run1(vecs[0], 1'b1, 1'b1, "s_clear_done_hit");

    repeat (4) @(posedge clock);
    #1;
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Multi-object successor to the single-pair bounding-box collision check.
- On a start pulse, snapshots one player box and NUM_OBSTACLES obstacle boxes, then tests them one per clock through a single shared comparator.
- Reports a per-obstacle hit mask, the lowest-index hit, a hit count, and a collision flag that is either live or sticky.
- Sits between the obstacle-update logic and the game-state FSM. Replaces per-frame combinational pair checks.

Parameters:
- NUM_OBSTACLES, 4, number of obstacle channels (1..16)
- X_BITWIDTH, 8, width of every x coordinate
- Y_BITWIDTH, 9, width of every y coordinate
- PLAYER_WIDTH, 50, player box width in pixels
- PLAYER_HEIGHT, 50, player box height in pixels
- OBS_WIDTH, 50, obstacle box width in pixels
- OBS_HEIGHT, 50, obstacle box height in pixels
- STICKY, 0, 1 = collision flag latches until clear; 0 = flag reflects the last completed scan

Ports:
- clock, input, 1, system clock
- reset, input, 1, asynchronous active-high reset
- start, input, 1, single-cycle scan request
- clear, input, 1, clears the sticky collision latch
- player_x, input, X_BITWIDTH, player top-left x
- player_y, input, Y_BITWIDTH, player top-left y
- obs_x, input, NUM_OBSTACLES*X_BITWIDTH, packed obstacle x coordinates; obstacle i at [i*X_BITWIDTH +: X_BITWIDTH]
- obs_y, input, NUM_OBSTACLES*Y_BITWIDTH, packed obstacle y coordinates, same packing
- obs_enable, input, NUM_OBSTACLES, per-obstacle active mask
- busy, output, 1, scan in progress
- done, output, 1, one-cycle pulse when results update
- collision, output, 1, collision flag
- hit_mask, output, NUM_OBSTACLES, bit i set = obstacle i overlapped in the last scan
- first_hit, output, clog2(NUM_OBSTACLES) (min 1), lowest hit index; 0 if no hits
- hit_count, output, clog2(NUM_OBSTACLES+1), number of hits in the last scan

Behaviour:
- Reset (asynchronous, any state, including mid-scan): all outputs 0, FSM to IDLE, snapshot and scratch registers 0. No partial results are ever published.
- FSM states:
  - IDLE: busy=0. start=1 at edge T captures all position inputs and obs_enable into snapshot registers, clears the scratch mask and count, sets index=0, goes to SCAN.
  - SCAN: busy=1. Each cycle tests obstacle[index] and ORs the result into scratch bit index. index increments; after index NUM_OBSTACLES-1 goes to DONE.
  - DONE: single cycle. Copies scratch to hit_mask, hit_count and first_hit; pulses done=1; updates collision; returns to IDLE.
- Latency: start sampled at edge T; done high in cycle T+NUM_OBSTACLES+1; busy high for NUM_OBSTACLES+1 cycles.
- Back-to-back scans: start is accepted in the IDLE cycle right after done.
- start while busy: ignored (no queueing).
- Inputs changing during a scan have no effect; only the snapshot is used.
- Overlap test, strict inequality: (px < ox+OBS_WIDTH) && (px+PLAYER_WIDTH > ox) && (py < oy+OBS_HEIGHT) && (py+PLAYER_HEIGHT > oy).
  - Edge-touching boxes do not collide.
- Arithmetic: each sum uses the coordinate width + 1 bit plus enough bits for the size constant, so no wrap. A box near the max coordinate must not alias to 0.
- A disabled obstacle (enable bit 0) never hits, regardless of position.
- hit_mask, first_hit and hit_count hold their values until the next DONE.
- STICKY=0: collision = |hit_mask, updated at DONE; clear has no effect.
- STICKY=1: collision set at DONE if any hit; cleared only by clear. If clear and DONE coincide, clear applies first, then the new scan result is ORed in.
- clear in any state does not affect the scan or hit_mask.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/SCAN/DONE)
  - width helper functions (clog2, sum width)
- Sub-module box_overlap:
  - purely combinational single-pair strict-overlap test
  - parametrised on the four coordinate widths and box sizes
  - instantiated once, muxed by the scan index

Test Plan:
- Defaults, player (10,10); obstacle0 (40,40), others (200,200); all enabled; start -> done exactly 5 cycles after start, hit_mask=0001, first_hit=0, hit_count=1, collision=1.
- Player (0,0), obstacle2 (50,0) (edge-touching); start -> hit_mask=0000, collision=0, hit_count=0.
- Obstacles 1 and 3 overlapping the player, obs_enable=0111; start -> hit_mask=0010, first_hit=1, hit_count=1.
- STICKY=1: scan with a hit -> collision=1; next scan with no hits -> collision stays 1; pulse clear -> collision=0; clear coincident with a hitting DONE -> collision=1.
- start pulses during busy, and obs_x changed mid-scan -> single done pulse; results match the snapshot taken at the accepted start.
- reset asserted on the 2nd SCAN cycle -> busy=0, done never pulses, all outputs 0; the next start runs a full clean scan.
- X_BITWIDTH=8, player_x=250, obstacle_x=0 -> no wrap-induced hit; hit_mask=0.
